// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone pipelined-mode initiator with a valid/ready command/response
// front end, slave stall support and a bus-timeout error response.
module wishbone_master #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_we,
    input  logic [ADDR_W-1:0]   cmd_adr,
    input  logic [DATA_W-1:0]   cmd_dat,
    input  logic [DATA_W/8-1:0] cmd_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_dat,
    output logic                rsp_err,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_stall_i,
    output logic                busy
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic [DATA_W/8-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic                ack_ok;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;
        ack_ok      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq, StWait: begin
                // An ack alongside stall is illegal in pipelined mode and is dropped.
                ack_ok = wb_ack_i && ((state_q == StWait) || !wb_stall_i);
                if (ack_ok) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? '0 : wb_dat_i;
                    state_d     = StResp;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((state_q == StReq) && !wb_stall_i) begin
                        stb_d   = 1'b0;
                        state_d = StWait;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;

endmodule

// File: doc/wishbone_master.md
Name: wishbone_master

Overview:
- Single-outstanding Wishbone pipelined-mode initiator. It is the driving end of the bus that our wishbone slave config block responds to.
- Test and bring-up logic uses it to issue reads and writes to the config and counter registers at 0x3000_0010 and 0x3000_0020.
- It sits between a simple valid/ready command/response interface and the Wishbone bus.
- It honours slave stall and provides a bus-timeout error response.

Parameters:
- TIMEOUT, 16: max cycles cyc_o stays high without ack_i before an error response; legal range 1..255.
- ADDR_W, 32: address width.
- DATA_W, 32: data width; SEL width = DATA_W/8.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  ADDR_W  target address.
- cmd_dat  in  DATA_W  write data.
- cmd_sel  in  DATA_W/8  byte selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_dat  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  timeout occurred.
- wb_cyc_o  out  1  bus cycle.
- wb_stb_o  out  1  strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  DATA_W/8  byte selects.
- wb_adr_o  out  ADDR_W  address.
- wb_dat_o  out  DATA_W  write data.
- wb_dat_i  in  DATA_W  read data.
- wb_ack_i  in  1  slave ack.
- wb_stall_i  in  1  slave stall.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs registered, except cmd_ready and busy, which are decoded from state.
- Reset (rst=0 at a rising edge):
  - state=IDLE.
  - wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_sel_o, wb_adr_o, wb_dat_o = 0.
  - rsp_valid=0, rsp_err=0, rsp_dat=0; timeout counter=0.
  - Reset mid-transfer drops cyc/stb on that edge; any pending response is discarded.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch we/adr/dat/sel onto the wb_* outputs, set cyc=stb=1, clear the counter, go to REQ.
  - Handshake in cycle 0 gives cyc/stb high in cycle 1.
- REQ:
  - stb held with stable adr/dat/sel/we while wb_stall_i=1.
  - If stall=0 and ack=0: stb<=0, go to WAIT.
  - If stall=0 and ack=1 in the same cycle: go to RESP.
  - ack while stall=1 is ignored (illegal in pipelined mode).
- WAIT: cyc=1, stb=0. On ack: go to RESP.
- Entering RESP on ack:
  - cyc<=0, stb<=0, rsp_valid<=1, rsp_err<=0.
  - rsp_dat<=wb_dat_i for reads, 0 for writes.
- Timeout:
  - Counter increments every cycle in REQ or WAIT without an accepted ack.
  - If cycles 1..TIMEOUT all lack ack, then at the end of cycle TIMEOUT: cyc<=0, stb<=0, rsp_valid<=1, rsp_err<=1, rsp_dat<=0, go to RESP.
  - If ack arrives in the same cycle the counter hits TIMEOUT, ack wins and the response is normal.
  - Counter width: clog2(TIMEOUT+1).
- RESP:
  - cmd_ready=0; rsp_* held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - The next command can be accepted the cycle after.
- Minimum turnaround, no stall, ack in cycle 1: cmd in cycle 0, rsp_valid in cycle 2, next cmd_ready in cycle 3 if rsp_ready=1 in cycle 2.
- ack_i in IDLE or RESP is ignored; no state or output change.
- wb_we_o/adr/sel/dat hold their last values after cyc drops. The slave must qualify them with cyc/stb.

Test Plan:
- Reset: drive rst=0 for 2 cycles while cmd_valid=1 -> cyc/stb/rsp_valid stay 0, cmd_ready=1 once rst=1.
- Write 0x3000_0010 data 0xA5A5_00FF, sel 0xF, stall=0, ack in cycle 2 -> cyc high in cycles 1-2, stb high in cycle 1 only, rsp_valid=1 from cycle 3 with rsp_err=0, rsp_dat=0.
- Read 0x3000_0020 with stall=1 in cycles 1-3, ack with wb_dat_i=0x1234_5678 in cycle 4 -> stb high in cycles 1-4 with stable adr, rsp_dat=0x1234_5678 from cycle 5.
- Timeout, TIMEOUT=16, no ack -> cyc high in cycles 1-16, low in cycle 17, rsp_valid=1, rsp_err=1, rsp_dat=0; a second run with ack in cycle 16 gives rsp_err=0.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_dat held, cmd_ready=0 throughout; cmd accepted the cycle after rsp_ready=1.
- Reset mid-WAIT: rst=0 in cycle 2 of a read -> cyc=0 next edge, no response issued, a stray ack afterwards is ignored.
